// File: rtl/dam_pkg.sv
// Shared types and opcode classification for the deferred-assertion monitor.
package dam_pkg;

  localparam int unsigned DEF_CH_W  = 2;
  localparam int unsigned DEF_OPC_W = 8;

  typedef enum logic [1:0] {
    ERR_LOW     = 2'd0,
    ERR_HIGH    = 2'd1,
    ERR_ILLEGAL = 2'd2
  } err_type_e;

  typedef enum logic [1:0] {
    CH_IDLE,
    CH_PEND,
    CH_MATURE,
    CH_HOLD
  } ch_state_e;

  typedef struct packed {
    logic [DEF_CH_W-1:0]  ch;
    err_type_e            etype;
    logic [DEF_OPC_W-1:0] opcode;
  } rpt_t;

  // Illegal range takes priority over the low/high split.
  function automatic err_type_e classify(input logic [31:0] opcode,
                                         input int unsigned split,
                                         input int unsigned max);
    if (opcode >= max)        return ERR_ILLEGAL;
    else if (opcode >= split) return ERR_HIGH;
    else                      return ERR_LOW;
  endfunction

endpackage

// File: rtl/dam_rpt_fifo.sv
// First-word-fall-through report queue; accepts a push while full if a pop happens in the same cycle.
module dam_rpt_fifo
  import dam_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter type         T     = rpt_t
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push,
  input  logic pop,
  input  T     wdata,
  output T     rdata,
  output logic full,
  output logic empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  T              mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [AW:0]   count;
  logic          wr;
  logic          rd;

  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);
  assign rd    = pop && !empty;
  assign wr    = push && (!full || rd);
  assign rdata = mem[rptr];

  always_ff @(posedge clk) begin
    if (wr) mem[wptr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (wr) wptr <= wptr + AW'(1);
      if (rd) rptr <= rptr + AW'(1);
      case ({wr, rd})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/deferred_assert_monitor.sv
// Multi-channel deferred-assertion monitor: per-channel flush-window FSMs,
// round-robin arbitration into a report queue, flush/drop statistics.
module deferred_assert_monitor
  import dam_pkg::*;
#(
  parameter int unsigned NUM_CH       = 4,
  parameter int unsigned OPC_W        = 8,
  parameter int unsigned DEFER_CYCLES = 2,
  parameter int unsigned OPC_SPLIT    = 32,
  parameter int unsigned OPC_MAX      = 64,
  parameter int unsigned FIFO_DEPTH   = 8,
  parameter int unsigned CNT_W        = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       en,
  input  logic [NUM_CH-1:0]          cond,
  input  logic [NUM_CH*OPC_W-1:0]    opcode,
  output logic                       rpt_valid,
  input  logic                       rpt_ready,
  output logic [$clog2(NUM_CH)-1:0]  rpt_ch,
  output logic [1:0]                 rpt_type,
  output logic [OPC_W-1:0]           rpt_opcode,
  output logic [CNT_W-1:0]           flush_cnt,
  output logic [CNT_W-1:0]           drop_cnt,
  output logic                       overflow
);

  localparam int unsigned CH_W = $clog2(NUM_CH);
  localparam int unsigned TW   = (DEFER_CYCLES > 1) ? $clog2(DEFER_CYCLES) : 1;
  localparam logic [TW-1:0] TIMER_INIT = TW'((DEFER_CYCLES > 0) ? DEFER_CYCLES - 1 : 0);

  typedef struct packed {
    logic [CH_W-1:0]  ch;
    err_type_e        etype;
    logic [OPC_W-1:0] opcode;
  } rpt_w_t;

  logic [NUM_CH-1:0]       mature;
  logic [NUM_CH-1:0]       grant;
  logic [NUM_CH-1:0]       flush;
  logic [NUM_CH*OPC_W-1:0] opc_vec;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    ch_state_e        state_q, state_d;
    logic [TW-1:0]    timer_q, timer_d;
    logic [OPC_W-1:0] opc_q, opc_d;
    logic             flush_ev;
    logic             c;

    assign c                          = cond[g];
    assign mature[g]                  = (state_q == CH_MATURE);
    assign flush[g]                   = flush_ev;
    assign opc_vec[g*OPC_W +: OPC_W]  = opc_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state_q <= CH_IDLE;
        timer_q <= '0;
        opc_q   <= '0;
      end else begin
        state_q <= state_d;
        timer_q <= timer_d;
        opc_q   <= opc_d;
      end
    end

    always_comb begin
      state_d  = state_q;
      timer_d  = timer_q;
      opc_d    = opc_q;
      flush_ev = 1'b0;
      if (!en) begin
        state_d = CH_IDLE;
      end else begin
        case (state_q)
          CH_IDLE: if (!c) begin
            opc_d   = opcode[g*OPC_W +: OPC_W];
            timer_d = TIMER_INIT;
            state_d = (DEFER_CYCLES == 0) ? CH_MATURE : CH_PEND;
          end
          CH_PEND: begin
            if (c) begin
              state_d  = CH_IDLE;
              flush_ev = 1'b1;
            end else if (timer_q == '0) begin
              state_d = CH_MATURE;
            end else begin
              timer_d = timer_q - TW'(1);
            end
          end
          CH_MATURE: if (grant[g]) state_d = CH_HOLD;
          CH_HOLD:   if (c) state_d = CH_IDLE;
          default:   state_d = CH_IDLE;
        endcase
      end
    end
  end

  logic [CH_W-1:0] ptr_q;
  logic [CH_W-1:0] idx;
  logic [CH_W-1:0] gnt_idx;
  logic            found;

  always_comb begin
    grant   = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      idx = CH_W'((32'(ptr_q) + i) % NUM_CH);
      if (!found && en && mature[idx]) begin
        found   = 1'b1;
        gnt_idx = idx;
      end
    end
    if (found) grant[gnt_idx] = 1'b1;
  end

  logic [OPC_W-1:0] opc_sel;
  rpt_w_t           wdata;
  rpt_w_t           head;
  logic             full;
  logic             empty;
  logic             pop;
  logic             drop;

  assign opc_sel      = opc_vec[gnt_idx*OPC_W +: OPC_W];
  assign wdata.ch     = gnt_idx;
  assign wdata.etype  = classify(32'(opc_sel), OPC_SPLIT, OPC_MAX);
  assign wdata.opcode = opc_sel;
  assign pop          = rpt_valid && rpt_ready;
  assign drop         = found && full && !pop;

  dam_rpt_fifo #(
    .DEPTH (FIFO_DEPTH),
    .T     (rpt_w_t)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (found),
    .pop   (pop),
    .wdata (wdata),
    .rdata (head),
    .full  (full),
    .empty (empty)
  );

  // Outputs are forced to zero while empty so stale queue words never show.
  assign rpt_valid  = !empty;
  assign rpt_ch     = empty ? '0 : head.ch;
  assign rpt_type   = empty ? 2'b00 : head.etype;
  assign rpt_opcode = empty ? '0 : head.opcode;

  logic [CNT_W:0] nflush;
  logic [CNT_W:0] flush_sum;

  always_comb begin
    nflush = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) nflush = nflush + (CNT_W+1)'(flush[i]);
    flush_sum = {1'b0, flush_cnt} + nflush;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q     <= '0;
      flush_cnt <= '0;
      drop_cnt  <= '0;
      overflow  <= 1'b0;
    end else begin
      if (found) ptr_q <= CH_W'((32'(gnt_idx) + 1) % NUM_CH);
      flush_cnt <= flush_sum[CNT_W] ? '1 : flush_sum[CNT_W-1:0];
      if (drop) begin
        overflow <= 1'b1;
        if (drop_cnt != '1) drop_cnt <= drop_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_deferred_assert_monitor.sv
// Directed self-checking bench: default-parameter monitor plus a zero-defer instance.
module tb_deferred_assert_monitor;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic [3:0]  cond;
  logic [31:0] opcode;
  logic        rpt_ready;
  logic        rpt_valid;
  logic [1:0]  rpt_ch;
  logic [1:0]  rpt_type;
  logic [7:0]  rpt_opcode;
  logic [15:0] flush_cnt;
  logic [15:0] drop_cnt;
  logic        overflow;

  logic [3:0]  cond_z;
  logic [31:0] opcode_z;
  logic        ready_z;
  logic        valid_z;
  logic [1:0]  ch_z;
  logic [1:0]  type_z;
  logic [7:0]  opc_z;
  logic [15:0] flush_z;
  logic [15:0] drop_z;
  logic        ovf_z;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  deferred_assert_monitor dut (
    .clk(clk), .rst_n(rst_n), .en(en), .cond(cond), .opcode(opcode),
    .rpt_valid(rpt_valid), .rpt_ready(rpt_ready), .rpt_ch(rpt_ch),
    .rpt_type(rpt_type), .rpt_opcode(rpt_opcode), .flush_cnt(flush_cnt),
    .drop_cnt(drop_cnt), .overflow(overflow)
  );

  deferred_assert_monitor #(.DEFER_CYCLES(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .en(en), .cond(cond_z), .opcode(opcode_z),
    .rpt_valid(valid_z), .rpt_ready(ready_z), .rpt_ch(ch_z),
    .rpt_type(type_z), .rpt_opcode(opc_z), .flush_cnt(flush_z),
    .drop_cnt(drop_z), .overflow(ovf_z)
  );

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; en = 1'b1; cond = '1; opcode = '0; rpt_ready = 1'b1;
    cond_z = '1; opcode_z = '0; ready_z = 1'b1;
    step(2);
    rst_n = 1'b1;
    step(1);
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if ({rpt_valid, rpt_ch, rpt_type, rpt_opcode, overflow} !== 14'd0) begin
      $display("FAIL reset_outputs: got v=%b ch=%0d t=%0d opc=%0d ovf=%b want all 0", rpt_valid, rpt_ch, rpt_type, rpt_opcode, overflow); n_fail++; end
    n_checks++; if ({flush_cnt, drop_cnt} !== 32'd0) begin
      $display("FAIL reset_counters: got flush=%0d drop=%0d want 0 0", flush_cnt, drop_cnt); n_fail++; end
    n_checks++; if (valid_z !== 1'b0) begin
      $display("FAIL reset_valid_z: got %b want 0", valid_z); n_fail++; end
  endtask

  task automatic test_flush();
    do_reset();
    cond[0] = 1'b0; step(1);
    cond[0] = 1'b1; step(1);
    n_checks++; if (flush_cnt !== 16'd1) begin
      $display("FAIL flush_count: got %0d want 1", flush_cnt); n_fail++; end
    step(4);
    n_checks++; if (rpt_valid !== 1'b0) begin
      $display("FAIL flush_no_report: got valid=%b want 0", rpt_valid); n_fail++; end
  endtask

  task automatic test_single_report();
    do_reset();
    opcode[15:8] = 8'd40; cond[1] = 1'b0;
    step(3);
    n_checks++; if (rpt_valid !== 1'b0) begin
      $display("FAIL single_early: got valid=%b want 0", rpt_valid); n_fail++; end
    step(1);
    n_checks++; if ({rpt_valid, rpt_ch, rpt_type, rpt_opcode} !== {1'b1, 2'd1, 2'd1, 8'd40}) begin
      $display("FAIL single_report: got v=%b ch=%0d t=%0d opc=%0d want v=1 ch=1 t=1 opc=40", rpt_valid, rpt_ch, rpt_type, rpt_opcode); n_fail++; end
    step(6);
    n_checks++; if (rpt_valid !== 1'b0) begin
      $display("FAIL single_no_repeat: got valid=%b want 0", rpt_valid); n_fail++; end
    cond[1] = 1'b1; step(2);
    n_checks++; if (flush_cnt !== 16'd0) begin
      $display("FAIL single_flush: got %0d want 0", flush_cnt); n_fail++; end
  endtask

  task automatic test_all_channels();
    logic [1:0] exp_type [4];
    logic [7:0] exp_opc  [4];
    exp_type = '{2'd0, 2'd1, 2'd2, 2'd0};
    exp_opc  = '{8'd5, 8'd33, 8'd70, 8'd10};
    do_reset();
    opcode = {8'd10, 8'd70, 8'd33, 8'd5};
    cond = '0;
    step(3);
    for (int i = 0; i < 4; i++) begin
      step(1);
      n_checks++; if ({rpt_valid, rpt_ch, rpt_type, rpt_opcode} !== {1'b1, 2'(i), exp_type[i], exp_opc[i]}) begin
        $display("FAIL all_ch_%0d: got v=%b ch=%0d t=%0d opc=%0d want v=1 ch=%0d t=%0d opc=%0d",
                 i, rpt_valid, rpt_ch, rpt_type, rpt_opcode, i, exp_type[i], exp_opc[i]); n_fail++; end
    end
    step(1);
    n_checks++; if (rpt_valid !== 1'b0) begin
      $display("FAIL all_ch_drained: got valid=%b want 0", rpt_valid); n_fail++; end
    cond = '1; step(2);
  endtask

  task automatic test_overflow();
    do_reset();
    rpt_ready = 1'b0;
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 4; c++) opcode[c*8 +: 8] = 8'(r*4 + c + 1);
      cond = (r < 2) ? 4'h0 : 4'hC;
      step(8);
      cond = '1;
      step(2);
    end
    n_checks++; if ({drop_cnt, overflow} !== {16'd2, 1'b1}) begin
      $display("FAIL ovf_drop: got drop=%0d ovf=%b want drop=2 ovf=1", drop_cnt, overflow); n_fail++; end
    rpt_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      n_checks++; if ({rpt_valid, rpt_ch, rpt_opcode} !== {1'b1, 2'(k % 4), 8'(k + 1)}) begin
        $display("FAIL ovf_drain_%0d: got v=%b ch=%0d opc=%0d want v=1 ch=%0d opc=%0d",
                 k, rpt_valid, rpt_ch, rpt_opcode, k % 4, k + 1); n_fail++; end
      step(1);
    end
    n_checks++; if ({rpt_valid, drop_cnt, overflow} !== {1'b0, 16'd2, 1'b1}) begin
      $display("FAIL ovf_after: got v=%b drop=%0d ovf=%b want v=0 drop=2 ovf=1", rpt_valid, drop_cnt, overflow); n_fail++; end
  endtask

  task automatic test_defer_zero();
    do_reset();
    opcode_z[23:16] = 8'd63; cond_z[2] = 1'b0;
    step(1);
    n_checks++; if (valid_z !== 1'b0) begin
      $display("FAIL d0_early: got valid=%b want 0", valid_z); n_fail++; end
    step(1);
    n_checks++; if ({valid_z, ch_z, type_z, opc_z} !== {1'b1, 2'd2, 2'd1, 8'd63}) begin
      $display("FAIL d0_high: got v=%b ch=%0d t=%0d opc=%0d want v=1 ch=2 t=1 opc=63", valid_z, ch_z, type_z, opc_z); n_fail++; end
    cond_z = '1; step(2);
    n_checks++; if (valid_z !== 1'b0) begin
      $display("FAIL d0_popped: got valid=%b want 0", valid_z); n_fail++; end
    opcode_z[23:16] = 8'd64; cond_z[2] = 1'b0;
    step(2);
    n_checks++; if ({valid_z, ch_z, type_z, opc_z} !== {1'b1, 2'd2, 2'd2, 8'd64}) begin
      $display("FAIL d0_illegal: got v=%b ch=%0d t=%0d opc=%0d want v=1 ch=2 t=2 opc=64", valid_z, ch_z, type_z, opc_z); n_fail++; end
    cond_z = '1; step(2);
  endtask

  task automatic test_async_reset();
    do_reset();
    rpt_ready = 1'b0;
    cond[0] = 1'b0; step(1); cond[0] = 1'b1; step(1);
    cond[1] = 1'b0; step(4);
    cond[2] = 1'b0; step(1);
    n_checks++; if ({rpt_valid, flush_cnt} !== {1'b1, 16'd1}) begin
      $display("FAIL ar_pre: got v=%b flush=%0d want v=1 flush=1", rpt_valid, flush_cnt); n_fail++; end
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if ({rpt_valid, rpt_ch, rpt_type, rpt_opcode, flush_cnt, drop_cnt, overflow} !== 46'd0) begin
      $display("FAIL ar_pend_zero: got v=%b ch=%0d t=%0d opc=%0d flush=%0d drop=%0d ovf=%b want all 0",
               rpt_valid, rpt_ch, rpt_type, rpt_opcode, flush_cnt, drop_cnt, overflow); n_fail++; end
    @(negedge clk);
    cond = '1; rst_n = 1'b1;
    step(3);
    n_checks++; if (rpt_valid !== 1'b0) begin
      $display("FAIL ar_no_partial: got valid=%b want 0", rpt_valid); n_fail++; end
    opcode[23:16] = 8'd7; cond[2] = 1'b0;
    step(3);
    n_checks++; if (rpt_valid !== 1'b0) begin
      $display("FAIL ar_redetect_early: got valid=%b want 0", rpt_valid); n_fail++; end
    step(1);
    n_checks++; if ({rpt_valid, rpt_ch, rpt_type, rpt_opcode} !== {1'b1, 2'd2, 2'd0, 8'd7}) begin
      $display("FAIL ar_redetect: got v=%b ch=%0d t=%0d opc=%0d want v=1 ch=2 t=0 opc=7", rpt_valid, rpt_ch, rpt_type, rpt_opcode); n_fail++; end
    step(1);
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (rpt_valid !== 1'b0) begin
      $display("FAIL ar_hold_zero: got valid=%b want 0", rpt_valid); n_fail++; end
    @(negedge clk);
    rst_n = 1'b1;
    step(3);
    n_checks++; if (rpt_valid !== 1'b0) begin
      $display("FAIL ar_hold_early: got valid=%b want 0", rpt_valid); n_fail++; end
    step(1);
    n_checks++; if ({rpt_valid, rpt_ch, rpt_opcode} !== {1'b1, 2'd2, 8'd7}) begin
      $display("FAIL ar_hold_redetect: got v=%b ch=%0d opc=%0d want v=1 ch=2 opc=7", rpt_valid, rpt_ch, rpt_opcode); n_fail++; end
    cond = '1; rpt_ready = 1'b1; step(2);
  endtask

  task automatic test_enable();
    do_reset();
    cond[3] = 1'b0; step(1);
    en = 1'b0; step(1);
    en = 1'b1; cond = '1; step(4);
    n_checks++; if ({rpt_valid, flush_cnt} !== {1'b0, 16'd0}) begin
      $display("FAIL en_discard: got v=%b flush=%0d want v=0 flush=0", rpt_valid, flush_cnt); n_fail++; end
  endtask

  initial begin
    test_reset();
    test_flush();
    test_single_report();
    test_all_channels();
    test_overflow();
    test_defer_zero();
    test_async_reset();
    test_enable();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
